fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Parametrised MIPS instruction-fetch stage. It replaces the discrete PC register, +4 adder and two-way PC mux with a single block. The block holds the PC and issues fetches to instruction memory over a request/grant/response handshake. It buffers returned instructions in a small queue feeding the IF/ID boundary and supports branch/jump redirect, exception vectoring and back-pressure stall.

Parameters:
XLEN, 32, address and instruction width
RESET_PC, 32'h0000_0000, PC value loaded on reset
EXC_VECTOR, 32'h0000_0080, PC loaded on exception
INC, 4, sequential PC increment in bytes (power of 2)
FQ_DEPTH, 2, fetch-queue entries (power of 2, >=2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
redirect_valid  input  1  branch/jump taken this cycle
redirect_pc  input  XLEN  branch/jump target
exc_valid  input  1  exception taken this cycle
imem_req  output  1  fetch request
imem_addr  output  XLEN  fetch address (= pc)
imem_gnt  input  1  memory accepts request this cycle
imem_rvalid  input  1  response data valid
imem_rdata  input  XLEN  fetched instruction
out_valid  output  1  head of queue valid toward decode
out_ready  input  1  decode accepts (low = stall)
out_pc  output  XLEN  PC of head instruction
out_instr  output  XLEN  head instruction

Behaviour:
- Reset (rst=1 at an edge) has priority over everything:
  - pc=RESET_PC, queue count=0, rd/wr pointers=0, outstanding=0, discard=0.
  - Outputs after reset: imem_req=0 while rst=1, out_valid=0. out_pc/out_instr are don't-care while out_valid=0.
- At most one outstanding memory transaction.
- Registers: pc (next address to request), req_pc (address of in-flight request), outstanding, discard, queue (pc+instr per entry), count.
- imem_req is combinational: !rst && !outstanding && (count < FQ_DEPTH) && !redirect_valid && !exc_valid.
  - imem_addr = pc always.
  - Request fires on imem_req && imem_gnt: outstanding<=1, req_pc<=pc, pc<=pc+INC (wraps modulo 2^XLEN).
- Response: imem_rvalid while outstanding clears outstanding the same edge.
  - If discard=1 or a flush occurs that cycle: data dropped, discard<=0.
  - Otherwise {req_pc, imem_rdata} is pushed at wr pointer and count increments.
  - imem_rvalid with outstanding=0 is ignored.
  - Response may arrive no earlier than the cycle after grant, so a response in the grant cycle cannot occur.
- Queue space is reserved at request time: count + outstanding <= FQ_DEPTH always, so a push never hits a full queue.
- Output:
  - out_valid = (count != 0); out_pc/out_instr come from the rd pointer entry.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo FQ_DEPTH.
- Flush is redirect_valid or exc_valid:
  - Next pc = EXC_VECTOR if exc_valid, else redirect_pc (exception wins), with the low log2(INC) bits forced to 0.
  - Queue emptied (count<=0, pointers<=0); a pop requested that cycle is ignored and out_valid falls next cycle.
  - If outstanding=1 and no response arrives this cycle: discard<=1.
  - imem_req is held low in the flush cycle, so the first request to the new target is issued the following cycle, or after the discarded response returns.
- Latency: request-to-out_valid is 1 cycle after imem_rvalid. Sequential throughput is limited by memory latency (single outstanding).
- Reset mid-transaction: outstanding and discard cleared. A late imem_rvalid after reset is ignored because outstanding=0.

Test Plan:
- Reset then free run: rst=1 for 2 cycles, gnt=1, rvalid 1 cycle after grant, out_ready=1 -> out_pc sequence 0x0,0x4,0x8,0xC with matching instr; imem_req=0 during rst.
- Stall/full: out_ready=0 with FQ_DEPTH=2 -> exactly 2 grants, then imem_req=0 and count=2. Raise out_ready -> entries drain in order 0x0,0x4, fetch resumes at 0x8.
- Redirect with in-flight: grant at pc=0x8, redirect_valid=1 to 0x40 next cycle, rvalid arrives after -> 0x8 data dropped, queue empty, next imem_addr=0x40, first out_pc=0x40.
- Exception vs redirect: exc_valid=1 and redirect_valid=1 (0x100) together -> next imem_addr=0x80, no 0x100 fetch.
- Flush coincident with response: rvalid and redirect_valid (0x20) same cycle -> response dropped, discard stays 0, next request at 0x20 issued the following cycle.
- Wrap and reset mid-flight: redirect to 0xFFFF_FFFC -> next sequential address 0x0. Assert rst while outstanding then rvalid -> no push, out_valid=0, pc=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: PC register, sequential increment and redirect mux,
// single-outstanding request/grant/response memory port and a small fetch queue toward decode.
module fetch_unit #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [XLEN-1:0] EXC_VECTOR = 32'h0000_0080,
    parameter int unsigned     INC        = 4,
    parameter int unsigned     FQ_DEPTH   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            exc_valid,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr
);

    localparam int unsigned     PW         = $clog2(FQ_DEPTH);
    localparam int unsigned     CW         = $clog2(FQ_DEPTH + 1);
    localparam logic [XLEN-1:0] INC_X      = XLEN'(INC);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INC - 1));
    localparam logic [CW-1:0]   DEPTH_C    = CW'(FQ_DEPTH);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_req_pc;
    logic            r_outstanding;
    logic            r_discard;
    logic [PW-1:0]   r_rd;
    logic [PW-1:0]   r_wr;
    logic [CW-1:0]   r_count;
    logic [XLEN-1:0] r_qpc    [FQ_DEPTH];
    logic [XLEN-1:0] r_qinstr [FQ_DEPTH];

    logic            w_flush;
    logic [XLEN-1:0] w_target;
    logic            w_fire;
    logic            w_resp;
    logic            w_push;
    logic            w_pop;

    // Exception vectoring takes precedence over a simultaneous branch/jump target.
    assign w_flush  = redirect_valid | exc_valid;
    assign w_target = (exc_valid ? EXC_VECTOR : redirect_pc) & ALIGN_MASK;

    // Only requesting with a free slot and nothing in flight keeps count + outstanding <= depth.
    assign imem_req  = !rst && !r_outstanding && (r_count < DEPTH_C) && !w_flush;
    assign imem_addr = r_pc;

    assign w_fire = imem_req && imem_gnt;
    assign w_resp = imem_rvalid && r_outstanding;
    assign w_push = !rst && w_resp && !r_discard && !w_flush;
    assign w_pop  = out_valid && out_ready && !w_flush;

    assign out_valid = (r_count != '0);
    assign out_pc    = r_qpc[r_rd];
    assign out_instr = r_qinstr[r_rd];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_outstanding <= 1'b0;
            r_discard     <= 1'b0;
            r_rd          <= '0;
            r_wr          <= '0;
            r_count       <= '0;
        end else begin
            if (w_flush) begin
                r_pc <= w_target;
            end else if (w_fire) begin
                r_pc <= r_pc + INC_X;
            end

            if (w_fire) begin
                r_req_pc      <= r_pc;
                r_outstanding <= 1'b1;
            end else if (w_resp) begin
                r_outstanding <= 1'b0;
            end

            // A flush with a request still in flight must swallow that stale response.
            if (w_resp) begin
                r_discard <= 1'b0;
            end else if (w_flush && r_outstanding) begin
                r_discard <= 1'b1;
            end

            if (w_flush) begin
                r_rd    <= '0;
                r_wr    <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_wr <= r_wr + PW'(1);
                end
                if (w_pop) begin
                    r_rd <= r_rd + PW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_qpc[r_wr]    <= r_req_pc;
            r_qinstr[r_wr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a memory responder plus a queue-based reference model of the
// fetched-instruction stream, exercised by directed scenarios and a randomized run.
module tb_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC  = 32'h0000_0080;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        exc;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        outValid;
    logic        outReady;
    logic [31:0] outPc;
    logic [31:0] outInstr;

    int checks = 0;
    int errors = 0;

    // Reference model state
    entry_t      mq[$];
    logic [31:0] mPc;
    logic [31:0] mReqPc;
    bit          mOut;
    bit          mDiscard;
    bit          modelValid = 0;

    // Memory responder state
    bit          memPending = 0;
    bit          memRespNow;
    int          memLat;
    logic [31:0] memAddr;
    int          minLat = 0;
    int          maxLat = 0;
    bit          gntEnable = 1;
    bit          gntRandom = 0;

    logic [31:0] popLog[$];
    logic [31:0] grantLog[$];
    int unsigned grantCount = 0;

    fetch_unit #(
        .XLEN      (32),
        .RESET_PC  (RESET_PC),
        .EXC_VECTOR(EXC_VEC),
        .INC       (4),
        .FQ_DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirectValid),
        .redirect_pc   (redirectPc),
        .exc_valid     (exc),
        .imem_req      (imemReq),
        .imem_addr     (imemAddr),
        .imem_gnt      (gnt),
        .imem_rvalid   (rvalid),
        .imem_rdata    (rdata),
        .out_valid     (outValid),
        .out_ready     (outReady),
        .out_pc        (outPc),
        .out_instr     (outInstr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instrOf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_F00D;
    endfunction

    // One clock: drive memory, compare DUT against the model, then advance both.
    task automatic cycle();
        bit          flush;
        bit          expReq;
        bit          respEff;
        bit          fire;
        logic        sReq;
        logic        sValid;
        logic [31:0] sAddr;
        entry_t      e;
        memRespNow = 0;
        if (memPending) begin
            if (memLat == 0) memRespNow = 1;
            else memLat--;
        end
        rvalid = memRespNow;
        rdata  = memRespNow ? instrOf(memAddr) : $urandom;
        #1;
        sReq   = imemReq;
        sAddr  = imemAddr;
        sValid = outValid;
        gnt    = gntEnable && !memPending && (!gntRandom || ($urandom_range(0, 1) == 1));
        #1;
        flush = redirectValid || exc;
        if (modelValid) begin
            expReq = !rst && !mOut && (mq.size() < DEPTH) && !flush;
            checks++;
            if (sReq !== expReq)
                begin errors++; $display("[TB] FAIL imem_req: got %b expected %b", sReq, expReq); end
            if (!rst) begin
                checks++;
                if (sAddr !== mPc)
                    begin errors++; $display("[TB] FAIL imem_addr: got %h expected %h", sAddr, mPc); end
            end
            checks++;
            if (sValid !== (mq.size() != 0))
                begin errors++; $display("[TB] FAIL out_valid: got %b expected %b", sValid, mq.size() != 0); end
            if (mq.size() != 0) begin
                checks += 2;
                if (outPc !== mq[0].pc)
                    begin errors++; $display("[TB] FAIL out_pc: got %h expected %h", outPc, mq[0].pc); end
                if (outInstr !== mq[0].instr)
                    begin errors++; $display("[TB] FAIL out_instr: got %h expected %h", outInstr, mq[0].instr); end
            end
        end
        fire = (sReq === 1'b1) && gnt;
        if (memRespNow) memPending = 0;
        if (fire) begin
            memPending = 1;
            memAddr    = sAddr;
            memLat     = $urandom_range(minLat, maxLat);
            grantCount++;
            grantLog.push_back(sAddr);
        end
        if (rst) begin
            mq.delete();
            mOut       = 0;
            mDiscard   = 0;
            mPc        = RESET_PC;
            modelValid = 1;
        end else if (modelValid) begin
            respEff = memRespNow && mOut;
            if ((mq.size() != 0) && outReady && !flush) begin
                popLog.push_back(mq[0].pc);
                void'(mq.pop_front());
            end
            if (respEff) begin
                mOut = 0;
                if (!mDiscard && !flush) begin
                    e.pc    = mReqPc;
                    e.instr = instrOf(mReqPc);
                    mq.push_back(e);
                end
                mDiscard = 0;
            end
            if (flush) begin
                mq.delete();
                if (mOut) mDiscard = 1;
                mPc = (exc ? EXC_VEC : redirectPc) & ~32'h3;
            end else if (fire) begin
                mOut   = 1;
                mReqPc = mPc;
                mPc    = mPc + 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic doReset(input int n);
        rst           = 1;
        redirectValid = 0;
        exc           = 0;
        repeat (n) cycle();
        rst = 0;
    endtask

    task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        outReady = 1; gntEnable = 1; gntRandom = 0; minLat = 0; maxLat = 0;
        doReset(2);
        #1;
        checkVal("reset_out_valid", 32'(outValid), 32'd0);
        checkVal("reset_imem_addr", imemAddr, RESET_PC);
        checkVal("reset_imem_req", 32'(imemReq), 32'd1);
    endtask

    task automatic test_free_run();
        popLog.delete();
        repeat (12) cycle();
        for (int i = 0; i < 4; i++)
            checkVal($sformatf("free_run_pc%0d", i), (popLog.size() > i) ? popLog[i] : 32'hDEAD_BEEF, 32'(i * 4));
    endtask

    task automatic test_stall();
        doReset(2);
        outReady = 0;
        popLog.delete();
        grantCount = 0;
        repeat (10) cycle();
        #1;
        checkVal("stall_grants", grantCount, 32'd2);
        checkVal("stall_req_low", 32'(imemReq), 32'd0);
        checkVal("stall_valid", 32'(outValid), 32'd1);
        outReady = 1;
        grantLog.delete();
        repeat (6) cycle();
        checkVal("drain_0", (popLog.size() > 0) ? popLog[0] : 32'hDEAD_BEEF, 32'h0);
        checkVal("drain_1", (popLog.size() > 1) ? popLog[1] : 32'hDEAD_BEEF, 32'h4);
        checkVal("resume_addr", (grantLog.size() > 0) ? grantLog[0] : 32'hDEAD_BEEF, 32'h8);
    endtask

    task automatic test_redirect_inflight();
        bit found = 0;
        bit sawStale = 0;
        doReset(2);
        outReady = 1; minLat = 2; maxLat = 2;
        grantLog.delete();
        for (int i = 0; i < 50 && !found; i++) begin
            cycle();
            if (grantLog.size() > 0 && grantLog[$] == 32'h8) found = 1;
        end
        checkVal("redirect_wait_grant8", 32'(found), 32'd1);
        popLog.delete();
        redirectValid = 1; redirectPc = 32'h40;
        cycle();
        redirectValid = 0;
        #1;
        checkVal("redirect_next_addr", imemAddr, 32'h40);
        repeat (15) cycle();
        checkVal("redirect_first_out", (popLog.size() > 0) ? popLog[0] : 32'hDEAD_BEEF, 32'h40);
        foreach (popLog[i]) if (popLog[i] == 32'h8) sawStale = 1;
        checkVal("redirect_stale_dropped", 32'(sawStale), 32'd0);
    endtask

    task automatic test_exc_priority();
        bit saw100 = 0;
        popLog.delete();
        grantLog.delete();
        exc = 1; redirectValid = 1; redirectPc = 32'h100;
        cycle();
        exc = 0; redirectValid = 0;
        #1;
        checkVal("exc_next_addr", imemAddr, EXC_VEC);
        repeat (12) cycle();
        checkVal("exc_first_out", (popLog.size() > 0) ? popLog[0] : 32'hDEAD_BEEF, EXC_VEC);
        foreach (grantLog[i]) if (grantLog[i] == 32'h100) saw100 = 1;
        checkVal("exc_no_redirect_fetch", 32'(saw100), 32'd0);
    endtask

    task automatic test_flush_with_resp();
        bit found = 0;
        minLat = 0; maxLat = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (memPending && memLat == 0 && mOut) found = 1;
            else cycle();
        end
        checkVal("flush_resp_wait", 32'(found), 32'd1);
        redirectValid = 1; redirectPc = 32'h22;
        cycle();
        redirectValid = 0;
        #1;
        checkVal("flush_resp_req", 32'(imemReq), 32'd1);
        checkVal("flush_resp_addr", imemAddr, 32'h20);
        grantLog.delete();
        cycle();
        checkVal("flush_resp_grant", (grantLog.size() > 0) ? grantLog[0] : 32'hDEAD_BEEF, 32'h20);
    endtask

    task automatic test_wrap_reset();
        int unsigned g0;
        bit found = 0;
        redirectValid = 1; redirectPc = 32'hFFFF_FFFC;
        cycle();
        redirectValid = 0;
        grantLog.delete();
        repeat (10) cycle();
        checkVal("wrap_first", (grantLog.size() > 0) ? grantLog[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        checkVal("wrap_second", (grantLog.size() > 1) ? grantLog[1] : 32'hDEAD_BEEF, 32'h0);
        minLat = 3; maxLat = 3;
        g0 = grantCount;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (grantCount != g0) found = 1;
        end
        checkVal("midflight_wait", 32'(found), 32'd1);
        rst = 1;
        cycle();
        rst = 0;
        #1;
        checkVal("midflight_addr", imemAddr, RESET_PC);
        for (int i = 0; i < 4; i++) begin
            cycle();
            checkVal($sformatf("midflight_valid%0d", i), 32'(outValid), 32'd0);
        end
    endtask

    task automatic test_random();
        gntRandom = 1; minLat = 0; maxLat = 3;
        for (int i = 0; i < 1500; i++) begin
            outReady      = ($urandom_range(0, 3) != 0);
            redirectValid = ($urandom_range(0, 15) == 0);
            redirectPc    = $urandom;
            exc           = ($urandom_range(0, 39) == 0);
            rst           = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 0; redirectValid = 0; exc = 0;
        repeat (5) cycle();
    endtask

    initial begin
        rst = 1; redirectValid = 0; redirectPc = '0; exc = 0;
        gnt = 0; rvalid = 0; rdata = '0; outReady = 1;
        @(negedge clk);
        test_reset();
        test_free_run();
        test_stall();
        test_redirect_inflight();
        test_exc_priority();
        test_flush_with_resp();
        test_wrap_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
